telem_frame_tx: RTL and testbench

Telemetry transmitter for the converter datapath. Accepts 8-bit measurement samples over a valid/ready handshake, buffers them in a small FIFO, and serializes them as framed UART bytes: sync, length, samples, checksum. Sits between the measurement/conversion core and a spare bidirectional pin driven as a serial output toward an off-chip logger or receiver.

---
 rtl/telem_frame_tx_if.sv | 11 +
 rtl/telem_frame_tx.sv | 200 ++++++++++++++++++++
 tb/tb_telem_frame_tx.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/telem_frame_tx_if.sv
// Sample handshake between the measurement core and telem_frame_tx.
// master: producer drives sample_in/sample_valid and observes sample_ready.
// slave: transmitter consumes samples and drives sample_ready.
interface telem_frame_tx_if;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       sample_ready;

  modport master (output sample_in, output sample_valid, input sample_ready);
  modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/telem_frame_tx.sv
// Purpose: buffers 8-bit samples and sends framed UART bytes: sync 0xA5, length, FRAME_LEN samples, checksum.
// Latency: SYNC start bit on tx one cycle after fifo_count reaches FRAME_LEN; each byte is 10*CLK_DIV cycles (11*CLK_DIV with parity).
// Backpressure: sample_ready = (count < FIFO_DEPTH), based only on count, so it stays low when full even if a pop lands the same cycle.
// Ports: clk, rst (async, active-high), ena (gates new frame starts), samples (slave: sample_in/sample_valid/sample_ready),
//        tx (serial out, idle high), busy, frame_done (pulse on last checksum stop cycle), fifo_count.
// Option: define TELEM_PARITY_EN to insert an even-parity bit between BIT7 and STOP.
module telem_frame_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FRAME_LEN  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  telem_frame_tx_if.slave  samples,
  output logic             tx,
  output logic             busy,
  output logic             frame_done,
  output logic [3:0]       fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(CLK_DIV);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [3:0] LEN4      = 4'(FRAME_LEN);
  localparam logic [7:0] LEN_BYTE  = {4'h0, LEN4};

  // Bit index within a byte: 0 = start, 1..8 = data LSB first, then parity (optional), then stop.
`ifdef TELEM_PARITY_EN
  localparam logic [3:0] PAR_IDX  = 4'd9;
  localparam logic [3:0] STOP_IDX = 4'd10;
`else
  localparam logic [3:0] STOP_IDX = 4'd9;
`endif

  typedef enum logic [2:0] {F_IDLE, F_SYNC, F_LEN, F_DATA, F_CSUM} frame_state_t;

  // Sample FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  // Frame and byte engine
  frame_state_t  state, state_nxt;
  logic [3:0]    bit_cnt;
  logic [DW-1:0] div_cnt;
  logic [7:0]    shreg;
  logic [7:0]    acc;
  logic [3:0]    data_cnt;
  logic          load;
  logic [7:0]    byte_nxt;
  logic          bit_end, byte_end, start_ok;
  logic [2:0]    bit_sel;

  assign samples.sample_ready = (count < CW'(FIFO_DEPTH));
  assign push       = samples.sample_valid && samples.sample_ready;
  assign fifo_count = 4'(count);

  assign bit_end  = (div_cnt == DW'(CLK_DIV - 1));
  assign byte_end = bit_end && (bit_cnt == STOP_IDX);
  assign start_ok = ena && (count >= CW'(FRAME_LEN));
  assign bit_sel  = bit_cnt[2:0] - 3'd1;  // bit_cnt 1..8 maps to data bit 0..7

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= samples.sample_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= F_IDLE;
    else     state <= state_nxt;
  end

  // Every byte boundary reloads the byte engine with the next byte; frames chain
  // directly from CSUM into SYNC so no idle bit appears between them.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    pop       = 1'b0;
    byte_nxt  = 8'h00;
    case (state)
      F_IDLE: begin
        if (start_ok) begin
          state_nxt = F_SYNC;
          load      = 1'b1;
          byte_nxt  = SYNC_BYTE;
        end
      end
      F_SYNC: begin
        if (byte_end) begin
          state_nxt = F_LEN;
          load      = 1'b1;
          byte_nxt  = LEN_BYTE;
        end
      end
      F_LEN: begin
        if (byte_end) begin
          state_nxt = F_DATA;
          load      = 1'b1;
          pop       = 1'b1;
          byte_nxt  = mem[rd_ptr];
        end
      end
      F_DATA: begin
        if (byte_end) begin
          load = 1'b1;
          if (data_cnt == LEN4) begin
            state_nxt = F_CSUM;
            byte_nxt  = 8'h00 - acc;
          end else begin
            pop      = 1'b1;
            byte_nxt = mem[rd_ptr];
          end
        end
      end
      F_CSUM: begin
        if (byte_end) begin
          if (start_ok) begin
            state_nxt = F_SYNC;
            load      = 1'b1;
            byte_nxt  = SYNC_BYTE;
          end else begin
            state_nxt = F_IDLE;
          end
        end
      end
      default: state_nxt = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= 8'h00;
      bit_cnt  <= 4'd0;
      div_cnt  <= '0;
      acc      <= 8'h00;
      data_cnt <= 4'd0;
    end else begin
      if (load) begin
        shreg   <= byte_nxt;
        bit_cnt <= 4'd0;
        div_cnt <= '0;
      end else if (state != F_IDLE) begin
        if (bit_end) begin
          div_cnt <= '0;
          bit_cnt <= bit_cnt + 4'd1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
      // Checksum covers LEN and data; it is seeded when LEN is loaded and
      // accumulates each sample as it leaves the FIFO.
      if (load && state_nxt == F_LEN) begin
        acc      <= LEN_BYTE;
        data_cnt <= 4'd0;
      end else if (pop) begin
        acc      <= acc + mem[rd_ptr];
        data_cnt <= data_cnt + 4'd1;
      end
    end
  end

  assign busy       = (state != F_IDLE);
  assign frame_done = (state == F_CSUM) && byte_end;

  // tx decodes registered state only, so reset drives it high asynchronously.
  always_comb begin
    tx = 1'b1;
    if (state != F_IDLE) begin
      if (bit_cnt == 4'd0) begin
        tx = 1'b0;
      end else if (bit_cnt <= 4'd8) begin
        tx = shreg[bit_sel];
`ifdef TELEM_PARITY_EN
      end else if (bit_cnt == PAR_IDX) begin
        tx = ^shreg;
`endif
      end
    end
  end

endmodule

// File: tb/tb_telem_frame_tx.sv
module tb_telem_frame_tx;
  localparam int CLK_DIV    = 4;
  localparam int FRAME_LEN  = 4;
  localparam int FIFO_DEPTH = 8;
`ifdef TELEM_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif
  localparam int BYTE_CYC  = BITS * CLK_DIV;
  localparam int FRAME_CYC = (FRAME_LEN + 3) * BYTE_CYC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       tx, busy, frame_done;
  logic [3:0] fifo_count;

  telem_frame_tx_if sif();

  telem_frame_tx #(.CLK_DIV(CLK_DIV), .FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .samples    (sif),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int rst_epoch = 0;
  logic [7:0] exp_q[$];  // expected serial bytes
  int busy_q[$];         // expected number of frames per busy run

  task automatic check_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  task automatic push(input logic [7:0] d);
    sif.sample_in    = d;
    sif.sample_valid = 1'b1;
    @(negedge clk);
    sif.sample_valid = 1'b0;
  endtask

  task automatic exp_frame(input logic [7:0] d0, d1, d2, d3, cs);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h04);
    exp_q.push_back(d0);
    exp_q.push_back(d1);
    exp_q.push_back(d2);
    exp_q.push_back(d3);
    exp_q.push_back(cs);
  endtask

  task automatic wait_busy(input logic level, input int limit, input string name);
    int n = 0;
    while (busy !== level && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq(name, int'(busy), int'(level));
  endtask

  initial forever begin
    @(posedge rst);
    rst_epoch++;
  end

  // UART decoder: samples mid-bit on falling edges, compares against exp_q
  // and checks that each frame's LEN+data+CSUM sums to zero.
  initial begin : decoder
    logic [7:0] b;
    logic       par;
    int         ep;
    int         framing_ok;
    int         pos;
    logic [7:0] sum;
    pos = 0;
    sum = 8'h00;
    par = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        ep = rst_epoch;
        framing_ok = 1;
        repeat (CLK_DIV / 2) @(negedge clk);
        if (tx !== 1'b0) framing_ok = 0;
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          b[i] = tx;
        end
`ifdef TELEM_PARITY_EN
        repeat (CLK_DIV) @(negedge clk);
        par = tx;
`endif
        repeat (CLK_DIV) @(negedge clk);
        if (tx !== 1'b1) framing_ok = 0;
        if (ep != rst_epoch) begin
          pos = 0;
          sum = 8'h00;
        end else begin
          check_eq("framing", framing_ok, 1);
`ifdef TELEM_PARITY_EN
          check_eq("parity_bit", int'(par), int'(^b));
`else
          par = 1'b0;
`endif
          if (exp_q.size() == 0) fail_now("unexpected_byte", int'(b));
          else check_eq("tx_byte", int'(b), int'(exp_q.pop_front()));
          if (pos == 0) sum = 8'h00;
          else sum = sum + b;
          if (pos == FRAME_LEN + 2) check_eq("frame_sum", int'(sum), 0);
          pos = (pos + 1) % (FRAME_LEN + 3);
        end
      end
    end
  end

  // busy/frame_done monitor: each busy run must last N frame times with N
  // frame_done pulses, the last one on the final busy cycle.
  initial begin : busy_mon
    int run, fd, fd_last, ep, frames;
    run = 0; fd = 0; fd_last = 0; ep = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        if (run == 0) ep = rst_epoch;
        run++;
        if (frame_done === 1'b1) begin
          fd++;
          fd_last = run;
        end
      end else begin
        if (frame_done === 1'b1) fail_now("frame_done_while_idle", 1);
        if (run > 0) begin
          if (ep == rst_epoch) begin
            if (busy_q.size() == 0) fail_now("unexpected_busy_run", run);
            else begin
              frames = busy_q.pop_front();
              check_eq("busy_cycles", run, frames * FRAME_CYC);
              check_eq("frame_done_pulses", fd, frames);
              check_eq("frame_done_last_cycle", fd_last, run);
            end
          end
          run = 0;
          fd = 0;
          fd_last = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lows;
    sif.sample_in    = 8'h00;
    sif.sample_valid = 1'b0;

    // Reset values while held and after release
    repeat (3) @(negedge clk);
    check_eq("rst_tx", int'(tx), 1);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_frame_done", int'(frame_done), 0);
    check_eq("rst_ready", int'(sif.sample_ready), 1);
    check_eq("rst_count", int'(fifo_count), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("post_rst_tx", int'(tx), 1);

    // Basic frame with start-latency checks
    ena = 1'b1;
    exp_frame(8'h96, 8'h2D, 8'h00, 8'hFF, 8'h3A);
    busy_q.push_back(1);
    push(8'h96);
    push(8'h2D);
    push(8'h00);
    push(8'hFF);
    check_eq("latency_busy_edge_n", int'(busy), 0);
    check_eq("latency_tx_edge_n", int'(tx), 1);
    check_eq("count_at_frame_len", int'(fifo_count), 4);
    @(negedge clk);
    check_eq("latency_busy_edge_n1", int'(busy), 1);
    check_eq("latency_tx_edge_n1", int'(tx), 0);
    wait_busy(1'b0, FRAME_CYC + 20, "basic_frame_end");
    check_eq("basic_count_empty", int'(fifo_count), 0);

    // Backpressure: fill with ena low, refuse a 9th sample, then two chained frames
    ena = 1'b0;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    push(8'h10); push(8'h20); push(8'h30); push(8'h40);
    check_eq("full_count", int'(fifo_count), 8);
    check_eq("full_ready", int'(sif.sample_ready), 0);
    push(8'h77);
    check_eq("ninth_rejected", int'(fifo_count), 8);
    check_eq("ena_low_no_start", int'(busy), 0);
    exp_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'hF2);
    exp_frame(8'h10, 8'h20, 8'h30, 8'h40, 8'h5C);
    busy_q.push_back(2);
    ena = 1'b1;
    wait_busy(1'b1, 5, "bp_start");
    wait_busy(1'b0, 2 * FRAME_CYC + 20, "bp_frames_end");
    check_eq("bp_count_empty", int'(fifo_count), 0);

    // Simultaneous push/pop on every DATA pop edge; pointers wrap
    ena = 1'b0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55); push(8'h66);
    exp_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h52);
    exp_frame(8'h55, 8'h66, 8'h0A, 8'h0B, 8'h2C);
    busy_q.push_back(2);
    ena = 1'b1;
    wait_busy(1'b1, 5, "pp_start");
    repeat (2 * BYTE_CYC - 1) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check_eq("pp_count_before", int'(fifo_count), 6);
      sif.sample_in    = 8'h0A + 8'(k);
      sif.sample_valid = 1'b1;
      @(negedge clk);
      sif.sample_valid = 1'b0;
      check_eq("pp_count_after", int'(fifo_count), 6);
      if (k < 3) repeat (BYTE_CYC - 1) @(negedge clk);
    end
    wait_busy(1'b0, 2 * FRAME_CYC + 20, "pp_frames_end");
    check_eq("pp_count_left", int'(fifo_count), 2);
    exp_frame(8'h0C, 8'h0D, 8'hE0, 8'hF0, 8'h13);
    busy_q.push_back(1);
    push(8'hE0);
    push(8'hF0);
    wait_busy(1'b1, 5, "pp3_start");
    wait_busy(1'b0, FRAME_CYC + 20, "pp3_end");

    // Reset in the middle of the first DATA byte
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h04);
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    wait_busy(1'b1, 5, "rstmid_start");
    repeat (2 * BYTE_CYC + BYTE_CYC / 2) @(negedge clk);
    check_eq("rstmid_in_data_tx_active", int'(busy), 1);
    rst = 1'b1;
    #1;
    check_eq("rstmid_tx_high", int'(tx), 1);
    check_eq("rstmid_busy", int'(busy), 0);
    check_eq("rstmid_count", int'(fifo_count), 0);
    check_eq("rstmid_bytes_seen", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // No activity after release until four new pushes; checksum wraps to 0x00
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    push(8'hFF); push(8'hFF); push(8'hFF);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check_eq("quiet_after_reset", lows, 0);
    check_eq("quiet_count", int'(fifo_count), 3);
    exp_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00);
    busy_q.push_back(1);
    push(8'hFF);
    wait_busy(1'b1, 5, "wrap_start");
    wait_busy(1'b0, FRAME_CYC + 20, "wrap_end");

    repeat (10) @(negedge clk);
    check_eq("bytes_outstanding", exp_q.size(), 0);
    check_eq("busy_runs_outstanding", busy_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
